// File: rtl/mem_ctrler.sv
// mem_ctrler: shares a byte-wide RAM port between line fetches and LSU accesses.
// Round-robin arbitration, then one byte access per cycle, little-endian assembly.
module mem_ctrler #(
   parameter int LINE_BYTES = 16,
   parameter int CNT_W      = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    if_valid,
   input  logic [31:0]             if_addr,
   output logic                    if_ready,
   output logic [LINE_BYTES*8-1:0] if_line,
   input  logic                    lsu_valid,
   input  logic                    lsu_write,
   input  logic [31:0]             lsu_addr,
   input  logic [1:0]              lsu_size,
   input  logic [31:0]             lsu_wdata,
   output logic                    lsu_ready,
   output logic [31:0]             lsu_rdata,
   input  logic [7:0]              mem_din,
   output logic [7:0]              mem_dout,
   output logic [31:0]             mem_a,
   output logic                    mem_wr
);
   localparam int OFS_W = $clog2(LINE_BYTES);

   typedef enum logic [2:0] {
      S_IDLE, S_IF_RD, S_LS_RD, S_LS_WR, S_DONE
   } state_t;

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [CNT_W-1:0]        r_n;
   logic [31:0]             r_base;
   logic [31:0]             r_wdata;
   logic                    r_last_lsu;
   logic                    r_replay;
   logic                    r_if_ready;
   logic                    r_lsu_ready;
   logic [LINE_BYTES*8-1:0] r_if_line;
   logic [31:0]             r_lsu_rdata;

   logic                    w_pick_if;
   logic                    w_pick_lsu;
   logic                    w_rd;
   logic                    w_in_range;
   logic [CNT_W-1:0]        w_idx;
   logic [CNT_W-1:0]        w_lsu_n;
   logic [31:0]             w_cnt32;
   logic [7:0]              w_wbyte;
   logic                    w_unused;

   assign w_pick_if  = if_valid && (!lsu_valid || r_last_lsu);
   assign w_pick_lsu = lsu_valid && !w_pick_if;
   assign w_rd       = (r_state == S_IF_RD) || (r_state == S_LS_RD);
   assign w_in_range = r_cnt < r_n;
   assign w_idx      = r_cnt - CNT_W'(1);
   assign w_cnt32    = 32'(r_cnt);
   assign w_unused   = ^if_addr[OFS_W-1:0];

   always_comb begin
      w_lsu_n = CNT_W'(4);
      case (lsu_size)
         2'd0:    w_lsu_n = CNT_W'(1);
         2'd1:    w_lsu_n = CNT_W'(2);
         default: w_lsu_n = CNT_W'(4);
      endcase
   end

   always_comb begin
      w_wbyte = r_wdata[7:0];
      case (r_cnt[1:0])
         2'd1:    w_wbyte = r_wdata[15:8];
         2'd2:    w_wbyte = r_wdata[23:16];
         2'd3:    w_wbyte = r_wdata[31:24];
         default: w_wbyte = r_wdata[7:0];
      endcase
   end

   // After a paused read, the byte in flight was lost: re-present it once.
   always_comb begin
      mem_a = '0;
      if (r_replay)
         mem_a = r_base + w_cnt32 - 32'd1;
      else if ((w_rd || r_state == S_LS_WR) && w_in_range)
         mem_a = r_base + w_cnt32;
   end

   assign mem_wr    = (r_state == S_LS_WR) && w_in_range && rdy;
   assign mem_dout  = (r_state == S_LS_WR) ? w_wbyte : 8'h00;
   assign if_ready  = r_if_ready;
   assign lsu_ready = r_lsu_ready;
   assign if_line   = r_if_line;
   assign lsu_rdata = r_lsu_rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_n         <= '0;
         r_base      <= '0;
         r_wdata     <= '0;
         r_last_lsu  <= 1'b1;
         r_replay    <= 1'b0;
         r_if_ready  <= 1'b0;
         r_lsu_ready <= 1'b0;
         r_if_line   <= '0;
         r_lsu_rdata <= '0;
      end else if (!rdy) begin
         if (w_rd && r_cnt != '0)
            r_replay <= 1'b1;
      end else if (r_replay) begin
         r_replay <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_pick_if) begin
                  r_state    <= S_IF_RD;
                  r_base     <= {if_addr[31:OFS_W], {OFS_W{1'b0}}};
                  r_n        <= CNT_W'(LINE_BYTES);
                  r_last_lsu <= 1'b0;
               end else if (w_pick_lsu) begin
                  r_state    <= lsu_write ? S_LS_WR : S_LS_RD;
                  r_base     <= lsu_addr;
                  r_n        <= w_lsu_n;
                  r_wdata    <= lsu_wdata;
                  r_last_lsu <= 1'b1;
                  if (!lsu_write)
                     r_lsu_rdata <= '0;
               end
            end
            S_IF_RD, S_LS_RD: begin
               if (r_cnt != '0) begin
                  for (int k = 0; k < LINE_BYTES; k++)
                     if (r_state == S_IF_RD && w_idx == CNT_W'(k))
                        r_if_line[8*k +: 8] <= mem_din;
                  for (int k = 0; k < 4; k++)
                     if (r_state == S_LS_RD && w_idx == CNT_W'(k))
                        r_lsu_rdata[8*k +: 8] <= mem_din;
               end
               if (r_cnt == r_n) begin
                  r_state     <= S_DONE;
                  r_if_ready  <= (r_state == S_IF_RD);
                  r_lsu_ready <= (r_state == S_LS_RD);
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_LS_WR: begin
               if (r_cnt == r_n - CNT_W'(1)) begin
                  r_state     <= S_DONE;
                  r_lsu_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               r_state     <= S_IDLE;
               r_if_ready  <= 1'b0;
               r_lsu_ready <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_ctrler.sv
// tb_mem_ctrler: byte-memory reference model, per-cycle compare process,
// directed transactions with hand-computed expectations.
module tb_mem_ctrler;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         rdy = 1'b1;
   logic         if_valid = 1'b0;
   logic [31:0]  if_addr = '0;
   logic         if_ready;
   logic [127:0] if_line;
   logic         lsu_valid = 1'b0;
   logic         lsu_write = 1'b0;
   logic [31:0]  lsu_addr = '0;
   logic [1:0]   lsu_size = '0;
   logic [31:0]  lsu_wdata = '0;
   logic         lsu_ready;
   logic [31:0]  lsu_rdata;
   logic [7:0]   mem_din = 8'h00;
   logic [7:0]   mem_dout;
   logic [31:0]  mem_a;
   logic         mem_wr;

   mem_ctrler #(.LINE_BYTES(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .if_valid(if_valid), .if_addr(if_addr),
      .if_ready(if_ready), .if_line(if_line),
      .lsu_valid(lsu_valid), .lsu_write(lsu_write),
      .lsu_addr(lsu_addr), .lsu_size(lsu_size),
      .lsu_wdata(lsu_wdata), .lsu_ready(lsu_ready),
      .lsu_rdata(lsu_rdata), .mem_din(mem_din),
      .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          ld;
      logic [31:0] d;
   } lsu_exp_t;

   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
   } wr_t;

   int n_err = 0;
   int n_chk = 0;
   bit auto_order = 1'b1;

   logic [7:0]   ram    [bit [31:0]];
   logic [7:0]   shadow [bit [31:0]];
   logic [127:0] exp_if[$];
   lsu_exp_t     exp_lsu[$];
   wr_t          exp_wr[$];
   bit           exp_order[$];
   logic [31:0]  tr [0:31];

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      n_chk++;
      n_err++;
      $display("FAIL %s", nm);
   endtask

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return a[7:0];
   endfunction

   function automatic logic [7:0] sh_rd(input logic [31:0] a);
      if (shadow.exists(a)) return shadow[a];
      return a[7:0];
   endfunction

   // Synchronous RAM: mem_din returns the byte addressed in the previous cycle.
   always @(posedge clk) begin
      logic [7:0] d;
      d = ram_rd(mem_a);
      if (mem_wr) ram[mem_a] = mem_dout;
      mem_din <= d;
   end

   always @(negedge clk) begin
      if (rst) begin
         if (if_ready && lsu_ready) fail("ready_overlap");
         if (!rdy && mem_wr) fail("wr_in_pause");
         if (mem_wr) begin
            if (exp_wr.size() == 0) begin
               fail("wr_unexpected");
            end else begin
               wr_t w;
               w = exp_wr.pop_front();
               chk("wr_addr", mem_a, w.a);
               chk("wr_data", mem_dout, w.d);
            end
         end
         if (if_ready || lsu_ready) begin
            if (exp_order.size() == 0) fail("order_empty");
            else chk("grant_order", lsu_ready, exp_order.pop_front());
         end
         if (if_ready) begin
            if (exp_if.size() == 0) fail("if_unexpected");
            else chk("if_line", if_line, exp_if.pop_front());
         end
         if (lsu_ready) begin
            if (exp_lsu.size() == 0) begin
               fail("lsu_unexpected");
            end else begin
               lsu_exp_t e;
               e = exp_lsu.pop_front();
               if (e.ld) chk("lsu_rdata", lsu_rdata, e.d);
            end
         end
      end
   end

   // Cycle 0 is the IDLE cycle where valid is first seen; lat = ready cycle.
   task automatic run_until(input bit want_if, input int pat,
                            input int plen, output int lat);
      lat = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (k < 32) tr[k] = mem_a;
         if (want_if ? if_ready : lsu_ready) begin
            lat = k;
            return;
         end
         @(posedge clk);
         #1;
         rdy = !(pat > 0 && k + 1 >= pat && k + 1 < pat + plen);
      end
   endtask

   task automatic if_req(input logic [31:0] a, input int pat,
                         input int plen, output int lat);
      logic [127:0] l;
      logic [31:0]  b;
      b = {a[31:4], 4'h0};
      for (int k = 0; k < 16; k++) l[8*k +: 8] = sh_rd(b + 32'(k));
      exp_if.push_back(l);
      if (auto_order) exp_order.push_back(1'b0);
      @(posedge clk);
      #1;
      if_valid = 1'b1;
      if_addr  = a;
      run_until(1'b1, pat, plen, lat);
      if (lat < 0) fail("if_timeout");
      @(posedge clk);
      #1;
      if_valid = 1'b0;
   endtask

   task automatic lsu_req(input bit wr, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] wd,
                          output int lat);
      lsu_exp_t e;
      int       n;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      e.ld = !wr;
      e.d  = '0;
      for (int c = 0; c < n; c++) begin
         if (wr) begin
            wr_t w;
            w.a = a + 32'(c);
            w.d = wd[8*c +: 8];
            exp_wr.push_back(w);
            shadow[w.a] = w.d;
         end else begin
            e.d[8*c +: 8] = sh_rd(a + 32'(c));
         end
      end
      exp_lsu.push_back(e);
      if (auto_order) exp_order.push_back(1'b1);
      @(posedge clk);
      #1;
      lsu_valid = 1'b1;
      lsu_write = wr;
      lsu_addr  = a;
      lsu_size  = sz;
      lsu_wdata = wd;
      run_until(1'b0, 0, 0, lat);
      if (lat < 0) fail("lsu_timeout");
      @(posedge clk);
      #1;
      lsu_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      int  lat2;
      bit  seen;
      wr_t w;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_if_ready", if_ready, 0);
      chk("rst_lsu_ready", lsu_ready, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_a", mem_a, 0);
      chk("rst_mem_dout", mem_dout, 0);
      chk("rst_if_line", if_line, 0);
      chk("rst_lsu_rdata", lsu_rdata, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // 1: reset in the middle of a word store (third byte)
      for (int c = 0; c < 3; c++) begin
         w.a = 32'h200 + 32'(c);
         w.d = 8'h44 - 8'(c * 8'h11);
         exp_wr.push_back(w);
         shadow[w.a] = w.d;
      end
      @(posedge clk);
      #1;
      lsu_valid = 1'b1;
      lsu_write = 1'b1;
      lsu_addr  = 32'h200;
      lsu_size  = 2'd2;
      lsu_wdata = 32'h1122_3344;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (mem_wr && mem_a == 32'h202) seen = 1'b1;
      end
      if (!seen) fail("rst_wr_cnt2_not_seen");
      #2;
      rst = 1'b0;
      #1;
      chk("rstmid_mem_wr", mem_wr, 0);
      chk("rstmid_lsu_ready", lsu_ready, 0);
      chk("rstmid_mem_a", mem_a, 0);
      lsu_valid = 1'b0;
      lsu_write = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (8) @(negedge clk);
      chk("rstmid_wr_left", exp_wr.size(), 0);
      chk("rstmid_idle_a", mem_a, 0);

      // 2: line read at 0x1234
      if_req(32'h0000_1234, 0, 0, lat);
      chk("if_lat", lat, 18);
      chk("if_a_first", tr[1], 32'h1230);
      chk("if_a_last", tr[16], 32'h123F);
      chk("if_line_lit", if_line,
          128'h3F3E3D3C_3B3A3938_37363534_33323130);

      // 3: word store then word load
      lsu_req(1'b1, 32'h100, 2'd2, 32'hDEAD_BEEF, lat);
      chk("st_lat", lat, 5);
      lsu_req(1'b0, 32'h100, 2'd2, 32'h0, lat);
      chk("ld_lat", lat, 6);
      chk("ld_word_lit", lsu_rdata, 32'hDEAD_BEEF);

      // 5: address wrap at the top of memory
      lsu_req(1'b1, 32'h0, 2'd0, 32'h0000_005A, lat);
      lsu_req(1'b0, 32'hFFFF_FFFF, 2'd0, 32'h0, lat);
      chk("ld_byte_lat", lat, 3);
      chk("ld_byte_lit", lsu_rdata, 32'h0000_00FF);
      lsu_req(1'b0, 32'hFFFF_FFFF, 2'd1, 32'h0, lat);
      chk("ld_half_lit", lsu_rdata, 32'h0000_5AFF);
      chk("half_a0", tr[1], 32'hFFFF_FFFF);
      chk("half_a1", tr[2], 32'h0000_0000);

      // 4: simultaneous requests, round robin
      auto_order = 1'b0;
      exp_order.push_back(1'b0);
      exp_order.push_back(1'b1);
      exp_order.push_back(1'b0);
      exp_order.push_back(1'b1);
      fork
         begin
            int l1;
            if_req(32'h40, 0, 0, l1);
            if_req(32'h80, 0, 0, l1);
         end
         begin
            int l2;
            lsu_req(1'b0, 32'h300, 2'd2, 32'h0, l2);
            lsu_req(1'b0, 32'h102, 2'd1, 32'h0, l2);
         end
      join
      chk("rr_half_lit", lsu_rdata, 32'h0000_DEAD);
      auto_order = 1'b1;
      if_req(32'hC0, 0, 0, lat);
      auto_order = 1'b0;
      exp_order.push_back(1'b1);
      exp_order.push_back(1'b0);
      fork
         if_req(32'hD0, 0, 0, lat);
         lsu_req(1'b0, 32'h100, 2'd3, 32'h0, lat2);
      join
      auto_order = 1'b1;

      // 6: pause during a line read at cnt=5
      if_req(32'h0000_010C, 6, 3, lat);
      chk("pause_lat", lat, 22);
      chk("pause_replay_a", tr[9], 32'h104);
      chk("pause_resume_a", tr[10], 32'h105);
      chk("pause_line_b0", if_line[31:0], 32'hDEAD_BEEF);
      rdy = 1'b1;

      repeat (4) @(negedge clk);
      chk("left_if", exp_if.size(), 0);
      chk("left_lsu", exp_lsu.size(), 0);
      chk("left_wr", exp_wr.size(), 0);
      chk("left_order", exp_order.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
